// File: rtl/scan_led_n.sv
// Multiplexed seven-segment scan driver: DIGITS hex digits on one segment bus,
// per-digit dp, leading-zero blanking, 16-level PWM brightness, frame snapshot.
module scan_led_n #(
    parameter int DIGITS      = 8,
    parameter int CLK_DIV     = 50000,
    parameter int DIG_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   d,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     dig,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int OW = PW + 5;

    localparam logic [DIGITS-1:0] DIG_IDLE = (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_IDLE = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [PW-1:0]         pre_r;
    logic [IW-1:0]         idx_r;
    logic [4*DIGITS-1:0]   snap_d_r;
    logic [DIGITS-1:0]     snap_dp_r;
    logic                  snap_blz_r;
    logic [OW-1:0]         on_cnt_r;
    logic [DIGITS-1:0]     dig_r;
    logic [7:0]            seg_r;
    logic                  frame_start_r;

    logic                  frame_cycle_s;
    logic                  pre_wrap_s;
    logic [OW-1:0]         on_prod_s;
    logic [3:0]            nib_s;
    logic                  dp_bit_s;
    logic                  nz_seen_s;
    logic                  blank_s;
    logic                  active_s;
    logic [7:0]            seg_on_s;
    logic [DIGITS-1:0]     dig_on_s;
    logic [DIGITS-1:0]     dig_nx_s;
    logic [7:0]            seg_nx_s;

    assign frame_cycle_s = (pre_r == '0) && (idx_r == '0);
    assign pre_wrap_s    = (pre_r == PW'(CLK_DIV - 1));
    // Full-width product so the >>4 sees every bit of (bright+1)*CLK_DIV.
    assign on_prod_s     = (OW'(bright) + OW'(1)) * OW'(CLK_DIV);

    // Decode current digit: nibble, dp and leading-zero state from the snapshot.
    always_comb begin
        nib_s     = 4'h0;
        dp_bit_s  = 1'b0;
        nz_seen_s = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (IW'(j) == idx_r) begin
                nib_s    = snap_d_r[4*(DIGITS-1-j) +: 4];
                dp_bit_s = snap_dp_r[DIGITS-1-j];
            end else begin
                nib_s    = nib_s;
                dp_bit_s = dp_bit_s;
            end
            if ((IW'(j) <= idx_r) && (snap_d_r[4*(DIGITS-1-j) +: 4] != 4'h0)) begin
                nz_seen_s = 1'b1;
            end else begin
                nz_seen_s = nz_seen_s;
            end
        end
        blank_s  = snap_blz_r && !nz_seen_s && (idx_r != IW'(DIGITS - 1));
        // pre==0 is always dark so adjacent digits never overlap.
        active_s = (pre_r != '0) && ({{(OW-PW){1'b0}}, pre_r} < on_cnt_r);
        seg_on_s = {dp_bit_s, blank_s ? 7'h00 : hex_to_seg(nib_s)};
        dig_on_s = DIGITS'(1) << (DIGITS - 1 - int'(idx_r));
        if (active_s) begin
            dig_nx_s = (DIG_ACT_LOW != 0) ? ~dig_on_s : dig_on_s;
            seg_nx_s = (SEG_ACT_LOW != 0) ? ~seg_on_s : seg_on_s;
        end else begin
            dig_nx_s = DIG_IDLE;
            seg_nx_s = SEG_IDLE;
        end
    end

    // Prescaler and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= '0;
            idx_r <= '0;
        end else if (pre_wrap_s) begin
            pre_r <= '0;
            idx_r <= (idx_r == IW'(DIGITS - 1)) ? IW'(0) : idx_r + IW'(1);
        end else begin
            pre_r <= pre_r + PW'(1);
            idx_r <= idx_r;
        end
    end

    // Frame snapshot, loaded once per frame so mid-frame input changes never tear.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_d_r   <= '0;
            snap_dp_r  <= '0;
            snap_blz_r <= 1'b0;
            on_cnt_r   <= '0;
        end else if (frame_cycle_s) begin
            snap_d_r   <= d;
            snap_dp_r  <= dp;
            snap_blz_r <= blank_lz;
            on_cnt_r   <= on_prod_s >> 4;
        end else begin
            snap_d_r   <= snap_d_r;
            snap_dp_r  <= snap_dp_r;
            snap_blz_r <= snap_blz_r;
            on_cnt_r   <= on_cnt_r;
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_r         <= DIG_IDLE;
            seg_r         <= SEG_IDLE;
            frame_start_r <= 1'b0;
        end else begin
            dig_r         <= dig_nx_s;
            seg_r         <= seg_nx_s;
            frame_start_r <= frame_cycle_s;
        end
    end

    assign dig         = dig_r;
    assign seg         = seg_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_scan_led_n.sv
// Bench for scan_led_n: cycle-time model checked every cycle on both polarities,
// plus a table of hand-computed expectations keyed by test phase and cycle.
module tb_scan_led_n;

    localparam int D     = 4;
    localparam int C     = 32;
    localparam int FRAME = D * C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bright = 4'h0;
    logic [3:0]  dig_lo, dig_hi;
    logic [7:0]  seg_lo, seg_hi;
    logic        fs_lo, fs_hi;

    int phase = 0;
    int vectors = 0;
    int miscompares = 0;

    scan_led_n #(.DIGITS(D), .CLK_DIV(C), .DIG_ACT_LOW(1), .SEG_ACT_LOW(1)) dut_lo (
        .clk(clk), .rst(rst), .d(d), .dp(dp), .blank_lz(blank_lz), .bright(bright),
        .dig(dig_lo), .seg(seg_lo), .frame_start(fs_lo));

    scan_led_n #(.DIGITS(D), .CLK_DIV(C), .DIG_ACT_LOW(0), .SEG_ACT_LOW(0)) dut_hi (
        .clk(clk), .rst(rst), .d(d), .dp(dp), .blank_lz(blank_lz), .bright(bright),
        .dig(dig_hi), .seg(seg_hi), .frame_start(fs_hi));

    always #5 clk = ~clk;

    function automatic logic [6:0] font(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    // Active-high {dig, seg} shown in the cycle after cycle tt of a run.
    function automatic logic [11:0] model_out(input int tt, input logic [15:0] sd,
                                              input logic [3:0] sdp, input logic sblz, input int son);
        int p, k;
        logic [15:0] hi;
        logic        blank;
        p = tt % C;
        k = (tt / C) % D;
        if (p < 1 || p >= son) return 12'h000;
        hi    = sd >> (4 * (D - 1 - k));
        blank = sblz && (k != D - 1) && (hi == 16'h0);
        return {4'(1 << (D - 1 - k)), sdp[D - 1 - k], blank ? 7'h00 : font(hi[3:0])};
    endfunction

    int          t = 0;
    logic        m_valid = 1'b0;
    logic [15:0] m_d;
    logic [3:0]  m_dp;
    logic        m_blz;
    int          m_on;
    logic [3:0]  e_dig;
    logic [7:0]  e_seg;
    logic        e_fs;

    // Reference model: t counts cycles since reset release.
    always @(posedge clk) begin
        if (rst) begin
            t       <= 0;
            m_valid <= 1'b1;
            m_d     <= 16'h0;
            m_dp    <= 4'h0;
            m_blz   <= 1'b0;
            m_on    <= 0;
            e_dig   <= 4'h0;
            e_seg   <= 8'h00;
            e_fs    <= 1'b0;
        end else begin
            {e_dig, e_seg} <= model_out(t, m_d, m_dp, m_blz, m_on);
            e_fs <= (t % FRAME == 0);
            if (t % FRAME == 0) begin
                m_d   <= d;
                m_dp  <= dp;
                m_blz <= blank_lz;
                m_on  <= ((int'(bright) + 1) * C) >> 4;
            end
            t <= t + 1;
        end
    end

    typedef struct {
        int         ph;
        int         cyc;
        bit         hi;
        logic [3:0] dig;
        logic [7:0] seg;
        logic       fs;
    } dchk_t;

    localparam int NCHK = 39;
    dchk_t dchk [NCHK] = '{
        '{1,   0, 1'b0, 4'hF, 8'hFF, 1'b0}, '{1,   0, 1'b1, 4'h0, 8'h00, 1'b0},
        '{1,   1, 1'b0, 4'hF, 8'hFF, 1'b1}, '{1,   2, 1'b0, 4'h7, 8'hF9, 1'b0},
        '{1,   2, 1'b1, 4'h8, 8'h06, 1'b0}, '{1,  32, 1'b0, 4'h7, 8'hF9, 1'b0},
        '{1,  33, 1'b0, 4'hF, 8'hFF, 1'b0}, '{1,  34, 1'b0, 4'hB, 8'hA4, 1'b0},
        '{1,  66, 1'b0, 4'hD, 8'h88, 1'b0}, '{1,  98, 1'b0, 4'hE, 8'h8E, 1'b0},
        '{1, 128, 1'b0, 4'hE, 8'h8E, 1'b0}, '{1, 129, 1'b0, 4'hF, 8'hFF, 1'b1},
        '{2,   2, 1'b0, 4'h7, 8'hFF, 1'b0}, '{2,  34, 1'b0, 4'hB, 8'hFF, 1'b0},
        '{2,  66, 1'b0, 4'hD, 8'hB0, 1'b0}, '{2,  98, 1'b0, 4'hE, 8'hC0, 1'b0},
        '{2, 130, 1'b0, 4'h7, 8'hFF, 1'b0}, '{2, 194, 1'b0, 4'hD, 8'hFF, 1'b0},
        '{2, 226, 1'b0, 4'hE, 8'hC0, 1'b0},
        '{3,   2, 1'b0, 4'h7, 8'hFF, 1'b0}, '{3,  34, 1'b0, 4'hB, 8'h7F, 1'b0},
        '{3,  66, 1'b0, 4'hD, 8'hFF, 1'b0}, '{3,  98, 1'b0, 4'hE, 8'h92, 1'b0},
        '{4,   2, 1'b0, 4'h7, 8'hF9, 1'b0}, '{4,   3, 1'b0, 4'hF, 8'hFF, 1'b0},
        '{4,  34, 1'b0, 4'hB, 8'hA4, 1'b0}, '{4,  35, 1'b0, 4'hF, 8'hFF, 1'b0},
        '{4, 130, 1'b0, 4'h7, 8'hF9, 1'b0}, '{4, 144, 1'b0, 4'h7, 8'hF9, 1'b0},
        '{4, 145, 1'b0, 4'hF, 8'hFF, 1'b0},
        '{5,  80, 1'b0, 4'hD, 8'hF9, 1'b0}, '{5,  98, 1'b0, 4'hE, 8'hF9, 1'b0},
        '{5, 130, 1'b0, 4'h7, 8'hA4, 1'b0}, '{5, 226, 1'b0, 4'hE, 8'hA4, 1'b0},
        '{6,   0, 1'b0, 4'hF, 8'hFF, 1'b0}, '{6,   0, 1'b1, 4'h0, 8'h00, 1'b0},
        '{6,   2, 1'b0, 4'h7, 8'hF9, 1'b0}, '{6,   2, 1'b1, 4'h8, 8'h06, 1'b0},
        '{6,  39, 1'b0, 4'hB, 8'hA4, 1'b0}
    };

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s phase=%0d t=%0d got=%h want=%h", nm, phase, t, act, exp);
        end
    endtask

    // Compare process: model every cycle, literal table where phase/cycle match.
    always @(negedge clk) begin
        if (m_valid) begin
            cmp("model_dig_lo", {4'h0, dig_lo}, {4'h0, ~e_dig});
            cmp("model_seg_lo", seg_lo, ~e_seg);
            cmp("model_fs_lo", {7'h0, fs_lo}, {7'h0, e_fs});
            cmp("model_dig_hi", {4'h0, dig_hi}, {4'h0, e_dig});
            cmp("model_seg_hi", seg_hi, e_seg);
            cmp("model_fs_hi", {7'h0, fs_hi}, {7'h0, e_fs});
            for (int i = 0; i < NCHK; i++) begin
                if (dchk[i].ph == phase && dchk[i].cyc == t) begin
                    if (dchk[i].hi) begin
                        cmp("lit_dig_hi", {4'h0, dig_hi}, {4'h0, dchk[i].dig});
                        cmp("lit_seg_hi", seg_hi, dchk[i].seg);
                        cmp("lit_fs_hi", {7'h0, fs_hi}, {7'h0, dchk[i].fs});
                    end else begin
                        cmp("lit_dig_lo", {4'h0, dig_lo}, {4'h0, dchk[i].dig});
                        cmp("lit_seg_lo", seg_lo, dchk[i].seg);
                        cmp("lit_fs_lo", {7'h0, fs_lo}, {7'h0, dchk[i].fs});
                    end
                end
            end
        end
    end

    task automatic start(input int ph, input logic [15:0] nd, input logic [3:0] ndp,
                         input logic nblz, input logic [3:0] nbr);
        @(posedge clk);
        #2;
        phase    = 0;
        rst      = 1'b1;
        d        = nd;
        dp       = ndp;
        blank_lz = nblz;
        bright   = nbr;
        repeat (2) @(posedge clk);
        #2;
        rst   = 1'b0;
        phase = ph;
    endtask

    task automatic at_cycle(input int c);
        int g;
        g = 0;
        while (t != c && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (t != c) begin
            $display("FAIL wait_cycle got=%0d want=%0d", t, c);
            $fatal(1, "cycle wait expired");
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        start(1, 16'h12AF, 4'b0000, 1'b0, 4'd15);
        at_cycle(135);
        start(2, 16'h0030, 4'b0000, 1'b1, 4'd15);
        at_cycle(100);
        d = 16'h0000;
        at_cycle(230);
        start(3, 16'h0005, 4'b0100, 1'b1, 4'd15);
        at_cycle(130);
        start(4, 16'h12AF, 4'b0000, 1'b0, 4'd0);
        at_cycle(10);
        bright = 4'd7;
        at_cycle(150);
        start(5, 16'h1111, 4'b0000, 1'b0, 4'd15);
        at_cycle(70);
        d = 16'h2222;
        at_cycle(230);
        start(6, 16'h12AF, 4'b0000, 1'b0, 4'd15);
        at_cycle(40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        at_cycle(40);
        at_cycle(60);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scan_led_n.md
# scan_led_n

Parametrised multiplexed seven-segment scan driver: time-multiplexes `DIGITS` hex digits onto a shared segment bus from the system clock, with no separate slow clock. It adds four features:
- per-digit decimal points;
- optional leading-zero blanking;
- 16-level brightness (PWM within each digit slot);
- tear-free frame snapshot of the display data.

It sits between the value/measurement logic (e.g. ADC result formatting) and the board's LED digit/segment pins.

## Interface
Parameters:
- `DIGITS`, 8, number of digits scanned, 1..16.
- `CLK_DIV`, 50000, clk cycles per digit slot; must be ≥ 32.
- `DIG_ACT_LOW`, 1, 1 = digit selects active-low, 0 = active-high.
- `SEG_ACT_LOW`, 1, 1 = segments active-low (common anode), 0 = active-high.

Ports:
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `d` input 4*DIGITS: hex data; digit 0 (leftmost) = `d[4*DIGITS-1 -: 4]`, last digit = `d[3:0]`.
- `dp` input DIGITS: decimal-point enables; `dp[DIGITS-1]` = digit 0.
- `blank_lz` input 1: 1 = blank leading zero digits.
- `bright` input 4: brightness, 0 = dimmest, 15 = full.
- `dig` output DIGITS: digit selects; `dig[DIGITS-1]` = digit 0.
- `seg` output 8: `seg[7]` = dp, `seg[6:0]` = g..a.
- `frame_start` output 1: one-cycle pulse at the start of each scan frame.

## Operation
- **Prescaler `pre`:** counts 0..CLK_DIV-1, then wraps to 0.
- **Digit index `idx`:** increments when `pre` wraps; after DIGITS-1 it wraps to 0.
- **Snapshot:**
  - At the end of every cycle with `pre==0 && idx==0`, `d`, `dp`, `blank_lz` and `bright` are captured into snapshot registers.
  - The display uses only the snapshot, so input changes mid-frame never tear the display.
  - In the same cycle the on-time is computed: `on_cnt = ((bright+1)*CLK_DIV) >> 4`. Width is ≥ clog2(CLK_DIV)+5 bits, with no truncation before the shift.
- **Digit active condition:** digit `idx` is active iff `1 <= pre < on_cnt`.
  - `pre==0` is a dead cycle in every slot (ghosting suppression).
  - `bright=15` gives on for CLK_DIV-1 of CLK_DIV cycles.
- **Segment encoding (internal active-high, g..a):**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - `seg[7]` = `dp` bit of the digit.
  - The whole byte is inverted if `SEG_ACT_LOW`, so active-low 0 = C0 and 8 = 80.
- **Leading-zero blank:**
  - Applies when snapshot `blank_lz=1`.
  - Digits 0..k-1 are blanked, where k is the index of the first nonzero nibble.
  - The last digit is never blanked, so all-zero data shows "0".
  - A blanked digit shows segments a–g off, but its dp is still shown.
- **Outputs when no digit is active:**
  - `dig` = all inactive (all 1s if `DIG_ACT_LOW`, all 0s otherwise).
  - `seg` = all off (FF active-low, 00 active-high).
  - Exactly one `dig` bit is ever active at a time.

## Timing
- `dig` and `seg` are registered: values computed from (`pre`, `idx`, snapshot) in cycle t appear in cycle t+1.
- `frame_start` is registered: it is high in the cycle after the `pre==0 && idx==0` cycle.
- **Reset:**
  - Any cycle with `rst=1` → at the next edge: `pre=0`, `idx=0`, snapshot cleared (data 0, dp 0, `blank_lz` 0, `bright` 0), `dig` all inactive, `seg` all off, `frame_start=0`.
  - Reset mid-frame aborts the scan immediately.
- **After reset release:**
  - Call the first cycle with `rst=0` cycle 0; it has `pre=0`, `idx=0`, and the snapshot is loaded at its end.
  - `frame_start=1` in cycle 1.
  - Digit 0 is first driven in cycle 2.
  - Digit k is driven in cycles k*CLK_DIV+2 .. k*CLK_DIV+on_cnt.
- **Frame period:** DIGITS*CLK_DIV cycles; `frame_start` pulses every DIGITS*CLK_DIV cycles.
- **Snapshot timing:** an input change in any cycle other than a frame's `pre==0, idx==0` cycle takes effect from the next frame only.

## Test plan
Use DIGITS=4, CLK_DIV=32, both polarities active-low unless stated.

1. **Basic scan.** `d`=16'h12AF, `bright`=15, `blank_lz`=0, `dp`=0 → `dig` sequence 0111, 1011, 1101, 1110.
   - `seg` = F9, 88, 8E?: the 2 digit shows A4, so the full sequence is F9, A4, 88, 8E.
   - Each digit is active 31 cycles; dead cycle with `dig`=1111, `seg`=FF between slots.
   - `frame_start` every 128 cycles.
2. **Leading-zero blank.**
   - `d`=16'h0030, `blank_lz`=1 → digits 0,1 show `seg`=FF, digit 2 shows B0, digit 3 shows C0.
   - `d`=0 → only digit 3 shows C0.
3. **Decimal point.** `dp`=4'b0100, `blank_lz`=1, `d`=16'h0005 → digit 1 shows `seg`=7F (blanked digit, dp lit); digit 3 shows 92.
4. **Brightness.**
   - `bright`=0 → `on_cnt`=2; each digit is active for exactly 1 cycle per slot.
   - `bright`=7 → `on_cnt`=16; each digit is active for 15 cycles.
5. **Snapshot and tear.** Change `d` from 16'h1111 to 16'h2222 while `idx`=2.
   - Digits 2–3 still show F9 in that frame.
   - All digits show A4 from the next frame.
6. **Reset and polarity.**
   - Assert `rst` mid-slot → next edge `dig`=1111, `seg`=FF; after release, digit 0 reappears in cycle 2.
   - Repeat with `DIG_ACT_LOW`=0, `SEG_ACT_LOW`=0 → idle `dig`=0000, `seg`=00; digit 0 of value 1 shows `dig`=1000, `seg`=06.
